ghost_mode_scheduler: RTL and testbench
=======================================

# ghost_mode_scheduler

Sequences global ghost behaviour for a round: the timed scatter/chase phase schedule, frightened mode on power-pellet pickup with end-of-fright flash warning, and the ghost-eaten combo index used for scoring. It sits beside the game controller. It consumes the game state, the level and the Pac-Man reload pulse, and drives the mode inputs of every ghost FSM and the score logic. All timing is counted in frame ticks.

## Interface

- TICKS_PER_SEC, default 60. Number of i_tick strobes per second.
- FLASH_SEC, default 2. Length of the fright-flash warning, in seconds.
- CNT_W, default 16. Width of the phase and fright tick counters.

- i_clk  in  1  system clock
- i_rst  in  1  reset; one clock, reset is synchronous and active-high
- i_tick  in  1  one-cycle frame strobe
- i_game_state  in  4  game state, GS_* encoding from params.vh
- i_level  in  8  current level, 1-based
- i_pacman_reload  in  1  pulse; restart round schedule (new level or life lost)
- i_power_pellet  in  1  pulse; power pellet eaten
- i_ghost_eaten  in  1  pulse; a frightened ghost was eaten
- o_ghost_mode  out  2  0 = SCATTER, 1 = CHASE, 2 = FRIGHT (3 unused)
- o_phase  out  3  schedule phase index, 0..7
- o_mode_reverse  out  1  one-cycle pulse; ghosts reverse direction
- o_fright_active  out  1  frightened mode in effect
- o_fright_flash  out  1  fright ends within FLASH_SEC
- o_ghost_combo  out  2  ghosts eaten in current fright, saturating at 3

## Operation

- **Phase schedule, in seconds.** Even phases are SCATTER, odd phases are CHASE. Phase 7 is CHASE with no time limit.
  - Level 1: 7, 20, 7, 20, 5, 20, 5.
  - Levels 2-4: 7, 20, 7, 20, 5, 60, 1.
  - Level ≥5: 5, 20, 5, 20, 5, 60, 1.
  - Level 0 is treated as level 1.
  - Phase duration in ticks is seconds × TICKS_PER_SEC.
- **Fright duration, in seconds.** Level 1..6 gives 7 − level. Level ≥7 gives 0.
- **Round restart.** Triggered by i_game_state ∉ {GS_PLAY, GS_PAUSE}, or by i_pacman_reload = 1 in any state. Effects:
  - phase = 0 and phase counter = 0;
  - fright cleared and combo = 0;
  - o_ghost_mode = SCATTER;
  - no reverse pulse.
- **GS_PAUSE.** All state is frozen. i_tick, i_power_pellet and i_ghost_eaten are ignored.
- **GS_PLAY, tick handling.**
  - Fright inactive: on i_tick the phase counter increments. When the counter reaches duration − 1 on a tick, the next cycle sets phase += 1, counter = 0, and pulses o_mode_reverse. In phase 7 the counter holds.
  - Fright active: on i_tick the fright counter increments and the phase counter is suspended. When the fright counter reaches fright_dur − 1 on a tick, fright ends. o_ghost_mode then returns to the mode of the current phase. No reverse pulse on fright exit.
- **Power pellet.**
  - Always pulses o_mode_reverse.
  - If fright_dur > 0: fright becomes active, fright counter = 0, combo = 0. A pellet during an active fright restarts it the same way.
  - If fright_dur = 0: only the reverse pulse; mode is unchanged.
- **Ghost eaten.** If fright is active, combo increments, saturating at 3. Otherwise it is ignored.
- **o_fright_flash.** Equals fright active AND (fright_dur_ticks − fright counter) ≤ FLASH_SEC × TICKS_PER_SEC.
- **Simultaneous events, per cycle:**
  - restart beats everything;
  - pellet beats tick: the tick is not counted on either counter, and a phase expiry due on that tick is deferred to the next tick;
  - ghost eaten together with pellet: combo = 0, the eat is dropped.
- **Level latching.** Durations are sampled from i_level on every restart. A level change mid-round takes effect at the next restart.

## Timing

- All outputs are registered. Each is updated on the clock edge that samples its triggering input, so it is visible one cycle after that input.
- Reset values: o_ghost_mode = 0, o_phase = 0, o_mode_reverse = 0, o_fright_active = 0, o_fright_flash = 0, o_ghost_combo = 0. All counters = 0.
- o_mode_reverse is exactly one cycle wide. It asserts in the same cycle that o_phase or o_ghost_mode changes.
- Reset asserted mid-fright or mid-phase returns everything to reset values on the next edge.
- Counters never wrap: the maximum count is 3600 at the defaults, well within CNT_W.

## Test plan

- **Schedule, level 1** (TICKS_PER_SEC = 4, GS_PLAY, tick every cycle): SCATTER for 28 ticks, then CHASE with phase 1 and one reverse pulse. CHASE lasts 80 ticks. Phase 7 is reached after 336 ticks and holds CHASE forever.
- **Fright at level 1**: pellet at phase 0, counter 10. Expect mode 2 and a reverse pulse. Flash rises after 16 fright ticks. After 24 ticks the mode returns to SCATTER with the phase counter still at 10, and there is no reverse pulse.
- **Level 7 pellet**: expect a reverse pulse only. o_fright_active stays 0 and the mode is unchanged.
- **Combo**: pellet, then 5 i_ghost_eaten pulses → combo 1, 2, 3, 3, 3. A second pellet → combo 0 and the fright timer restarts.
- **Pause**: enter GS_PAUSE mid-fright and apply 100 ticks. Expect all outputs and counters unchanged. On return to GS_PLAY, counting resumes from the same count.
- **Restart and precedence**:
  - i_pacman_reload during fright → mode 0, phase 0, no reverse.
  - Pellet on the same cycle as a phase-expiry tick → FRIGHT, phase unchanged.
  - i_rst mid-phase 3 → all outputs 0 next cycle.

Source files
------------

// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler
//   Sequences the round-wide ghost behaviour: the timed scatter/chase phase
//   schedule, frightened mode after a power pellet (with an end-of-fright
//   flash warning) and the ghost-eaten combo index used for scoring.
//   All timing is counted in frame ticks (i_tick strobes).
//
// Parameters
//   TICKS_PER_SEC  i_tick strobes per second
//   FLASH_SEC      length of the fright-flash warning, in seconds
//   CNT_W          width of the phase and fright tick counters
//   GS_PLAY        game-state code for active play (matches params.vh)
//   GS_PAUSE       game-state code for pause (matches params.vh)
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_tick             one-cycle frame strobe
//   i_game_state       current game state
//   i_level            current level, 1-based (0 behaves as 1)
//   i_pacman_reload    pulse, restart the round schedule
//   i_power_pellet     pulse, power pellet eaten
//   i_ghost_eaten      pulse, a frightened ghost was eaten
//   o_ghost_mode       0 scatter, 1 chase, 2 fright
//   o_phase            schedule phase 0..7
//   o_mode_reverse     one-cycle pulse, ghosts reverse direction
//   o_fright_active    frightened mode in effect
//   o_fright_flash     fright ends within FLASH_SEC
//   o_ghost_combo      ghosts eaten in this fright, saturating at 3
module ghost_mode_scheduler #(
  parameter int         TICKS_PER_SEC = 60,
  parameter int         FLASH_SEC     = 2,
  parameter int         CNT_W         = 16,
  parameter logic [3:0] GS_PLAY       = 4'd2,
  parameter logic [3:0] GS_PAUSE      = 4'd3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic [3:0] i_game_state,
  input  logic [7:0] i_level,
  input  logic       i_pacman_reload,
  input  logic       i_power_pellet,
  input  logic       i_ghost_eaten,
  output logic [1:0] o_ghost_mode,
  output logic [2:0] o_phase,
  output logic       o_mode_reverse,
  output logic       o_fright_active,
  output logic       o_fright_flash,
  output logic [1:0] o_ghost_combo
);

  typedef enum logic [1:0] {
    MODE_SCATTER = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_FRIGHT  = 2'd2
  } mode_e;

  localparam logic [CNT_W-1:0] TPS_C       = CNT_W'(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] FLASH_TICKS = CNT_W'(FLASH_SEC * TICKS_PER_SEC);

  // Phase length in seconds; phase 7 is unbounded and returns 0.
  function automatic logic [7:0] phase_sec(input logic [7:0] lvl, input logic [2:0] ph);
    logic [7:0] s;
    s = 8'd0;
    case (ph)
      3'd0, 3'd2: s = (lvl >= 8'd5) ? 8'd5 : 8'd7;
      3'd1, 3'd3: s = 8'd20;
      3'd4:       s = 8'd5;
      3'd5:       s = (lvl <= 8'd1) ? 8'd20 : 8'd60;
      3'd6:       s = (lvl <= 8'd1) ? 8'd5 : 8'd1;
      default:    s = 8'd0;
    endcase
    return s;
  endfunction

  // Fright length in seconds; level 0 behaves as level 1, level 7+ has none.
  function automatic logic [7:0] fright_sec(input logic [7:0] lvl);
    logic [7:0] s;
    if (lvl == 8'd0) begin
      s = 8'd6;
    end else if (lvl >= 8'd7) begin
      s = 8'd0;
    end else begin
      s = 8'd7 - lvl;
    end
    return s;
  endfunction

  logic [7:0]       level_q, level_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic             fright_q, fright_d;
  logic [CNT_W-1:0] fright_cnt_q, fright_cnt_d;
  logic [1:0]       combo_q, combo_d;
  mode_e            mode_q, mode_d;
  logic             reverse_q, reverse_d;
  logic             flash_q, flash_d;

  logic [CNT_W-1:0] phase_ticks_s;
  logic [CNT_W-1:0] fright_ticks_s;
  logic             restart_s;

  assign phase_ticks_s  = CNT_W'(phase_sec(level_q, phase_q)) * TPS_C;
  assign fright_ticks_s = CNT_W'(fright_sec(level_q)) * TPS_C;
  assign restart_s      = i_pacman_reload ||
                          ((i_game_state != GS_PLAY) && (i_game_state != GS_PAUSE));

  // Next-state logic: restart, pause freeze, then pellet/eat/tick handling.
  always_comb begin
    level_d      = level_q;
    phase_d      = phase_q;
    phase_cnt_d  = phase_cnt_q;
    fright_d     = fright_q;
    fright_cnt_d = fright_cnt_q;
    combo_d      = combo_q;
    reverse_d    = 1'b0;

    if (restart_s) begin
      level_d      = i_level;
      phase_d      = 3'd0;
      phase_cnt_d  = '0;
      fright_d     = 1'b0;
      fright_cnt_d = '0;
      combo_d      = 2'd0;
    end else if (i_game_state == GS_PAUSE) begin
      level_d = level_q;
    end else if (i_power_pellet) begin
      // Pellet swallows any tick and eat on the same cycle.
      reverse_d = 1'b1;
      if (fright_ticks_s != '0) begin
        fright_d     = 1'b1;
        fright_cnt_d = '0;
        combo_d      = 2'd0;
      end else begin
        fright_d = fright_q;
      end
    end else begin
      if (i_ghost_eaten && fright_q && (combo_q != 2'd3)) begin
        combo_d = combo_q + 2'd1;
      end else begin
        combo_d = combo_q;
      end
      if (i_tick) begin
        if (fright_q) begin
          // Phase counter is suspended while frightened.
          if (fright_cnt_q == (fright_ticks_s - CNT_W'(1))) begin
            fright_d     = 1'b0;
            fright_cnt_d = '0;
          end else begin
            fright_cnt_d = fright_cnt_q + CNT_W'(1);
          end
        end else if (phase_q != 3'd7) begin
          if (phase_cnt_q == (phase_ticks_s - CNT_W'(1))) begin
            phase_d     = phase_q + 3'd1;
            phase_cnt_d = '0;
            reverse_d   = 1'b1;
          end else begin
            phase_cnt_d = phase_cnt_q + CNT_W'(1);
          end
        end else begin
          phase_cnt_d = phase_cnt_q;
        end
      end else begin
        phase_cnt_d = phase_cnt_q;
      end
    end

    // Output mode and flash follow the next state so they land with it.
    if (fright_d) begin
      mode_d = MODE_FRIGHT;
    end else if (phase_d[0]) begin
      mode_d = MODE_CHASE;
    end else begin
      mode_d = MODE_SCATTER;
    end
    flash_d = fright_d && ((fright_ticks_s - fright_cnt_d) <= FLASH_TICKS);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      level_q      <= 8'd0;
      phase_q      <= 3'd0;
      phase_cnt_q  <= '0;
      fright_q     <= 1'b0;
      fright_cnt_q <= '0;
      combo_q      <= 2'd0;
      mode_q       <= MODE_SCATTER;
      reverse_q    <= 1'b0;
      flash_q      <= 1'b0;
    end else begin
      level_q      <= level_d;
      phase_q      <= phase_d;
      phase_cnt_q  <= phase_cnt_d;
      fright_q     <= fright_d;
      fright_cnt_q <= fright_cnt_d;
      combo_q      <= combo_d;
      mode_q       <= mode_d;
      reverse_q    <= reverse_d;
      flash_q      <= flash_d;
    end
  end

  assign o_ghost_mode    = mode_q;
  assign o_phase         = phase_q;
  assign o_mode_reverse  = reverse_q;
  assign o_fright_active = fright_q;
  assign o_fright_flash  = flash_q;
  assign o_ghost_combo   = combo_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Self-checking bench for ghost_mode_scheduler at TICKS_PER_SEC = 4.
module tb_ghost_mode_scheduler;

  localparam int         TPS     = 4;
  localparam int         FS      = 2;
  localparam int         CW      = 16;
  localparam int         FLASH_T = FS * TPS;
  localparam logic [3:0] GS_IDLE  = 4'd0;
  localparam logic [3:0] GS_PLAY  = 4'd2;
  localparam logic [3:0] GS_PAUSE = 4'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] gs;
  logic [7:0] lvl;
  logic       reload;
  logic       pellet;
  logic       eaten;
  logic [1:0] o_ghost_mode;
  logic [2:0] o_phase;
  logic       o_mode_reverse;
  logic       o_fright_active;
  logic       o_fright_flash;
  logic [1:0] o_ghost_combo;

  always #5 clk = ~clk;

  ghost_mode_scheduler #(
    .TICKS_PER_SEC(TPS), .FLASH_SEC(FS), .CNT_W(CW),
    .GS_PLAY(GS_PLAY), .GS_PAUSE(GS_PAUSE)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_game_state(gs), .i_level(lvl),
    .i_pacman_reload(reload), .i_power_pellet(pellet), .i_ghost_eaten(eaten),
    .o_ghost_mode(o_ghost_mode), .o_phase(o_phase), .o_mode_reverse(o_mode_reverse),
    .o_fright_active(o_fright_active), .o_fright_flash(o_fright_flash),
    .o_ghost_combo(o_ghost_combo)
  );

  typedef struct packed {
    logic [1:0] mode;
    logic [2:0] ph;
    logic       rev;
    logic       fa;
    logic       ff;
    logic [1:0] cb;
  } out_t;

  typedef struct packed {
    logic [3:0] gs;
    logic [7:0] lvl;
    logic       rl;
    logic       pp;
    logic       ge;
    logic       tk;
    out_t       e;
  } vec_t;

  out_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[15];

  function automatic out_t mk(input logic [1:0] m, input logic [2:0] p, input logic r,
                              input logic fa, input logic ff, input logic [1:0] c);
    out_t o;
    o.mode = m; o.ph = p; o.rev = r; o.fa = fa; o.ff = ff; o.cb = c;
    return o;
  endfunction

  function automatic vec_t mkv(input logic [3:0] g, input logic [7:0] l, input logic rl,
                               input logic pp, input logic ge, input logic tk, input out_t e);
    vec_t v;
    v.gs = g; v.lvl = l; v.rl = rl; v.pp = pp; v.ge = ge; v.tk = tk; v.e = e;
    return v;
  endfunction

  // Level-1 schedule with no fright: expected outputs after n counted phase ticks.
  function automatic out_t sched_exp(input int n);
    int         b[7];
    logic [2:0] ph;
    logic       rev;
    b = '{28, 108, 136, 216, 236, 316, 336};
    ph  = 3'd0;
    rev = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (n >= b[i]) ph = ph + 3'd1;
      if (n == b[i]) rev = 1'b1;
    end
    return mk(ph[0] ? 2'd1 : 2'd0, ph, rev, 1'b0, 1'b0, 2'd0);
  endfunction

  task automatic check(input string nm);
    out_t got;
    out_t want;
    got  = {o_ghost_mode, o_phase, o_mode_reverse, o_fright_active, o_fright_flash, o_ghost_combo};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t: got mode=%0d ph=%0d rev=%0b fa=%0b ff=%0b cb=%0d, want mode=%0d ph=%0d rev=%0b fa=%0b ff=%0b cb=%0d",
               nm, $time, got.mode, got.ph, got.rev, got.fa, got.ff, got.cb,
               want.mode, want.ph, want.rev, want.fa, want.ff, want.cb);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic cyc(input logic [3:0] g, input logic rl, input logic pp, input logic ge,
                     input logic tk, input out_t e, input string nm);
    gs = g; reload = rl; pellet = pp; eaten = ge; tick = tk;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(nm);
  endtask

  task automatic restart(input logic [7:0] l);
    lvl = l;
    cyc(GS_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0), "restart");
  endtask

  // n fright ticks from fright count 'start' of an F-tick fright in phase ph.
  task automatic fright_run(input int f, input int start, input int n, input logic [2:0] ph,
                            input logic [1:0] cb, input out_t after, input string nm);
    for (int k = 1; k <= n; k++) begin
      if (start + k >= f) begin
        cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, after, nm);
      end else begin
        cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1,
            mk(2'd2, ph, 1'b0, 1'b1, ((f - start - k) <= FLASH_T), cb), nm);
      end
    end
  endtask

  initial begin
    out_t z;
    z = mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    vecs[0]  = mkv(GS_IDLE, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, z);
    vecs[1]  = mkv(GS_PLAY, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd2, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0));
    vecs[2]  = mkv(GS_PLAY, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, mk(2'd2, 3'd0, 1'b0, 1'b1, 1'b0, 2'd1));
    vecs[3]  = mkv(GS_PLAY, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, mk(2'd2, 3'd0, 1'b0, 1'b1, 1'b0, 2'd2));
    vecs[4]  = mkv(GS_PLAY, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, mk(2'd2, 3'd0, 1'b0, 1'b1, 1'b0, 2'd3));
    vecs[5]  = mkv(GS_PLAY, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, mk(2'd2, 3'd0, 1'b0, 1'b1, 1'b0, 2'd3));
    vecs[6]  = mkv(GS_PLAY, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, mk(2'd2, 3'd0, 1'b0, 1'b1, 1'b0, 2'd3));
    vecs[7]  = mkv(GS_PLAY, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd2, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0));
    vecs[8]  = mkv(GS_PLAY, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, mk(2'd2, 3'd0, 1'b0, 1'b1, 1'b0, 2'd1));
    vecs[9]  = mkv(GS_PLAY, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, mk(2'd2, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0));
    vecs[10] = mkv(GS_IDLE, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, z);
    vecs[11] = mkv(GS_PLAY, 8'd7, 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0));
    vecs[12] = mkv(GS_PLAY, 8'd7, 1'b0, 1'b0, 1'b1, 1'b0, z);
    vecs[13] = mkv(GS_PLAY, 8'd7, 1'b0, 1'b1, 1'b1, 1'b0, mk(2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0));
    vecs[14] = mkv(GS_PLAY, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, z);

    rst = 1'b1; gs = GS_IDLE; lvl = 8'd1; reload = 1'b0; pellet = 1'b0; eaten = 1'b0; tick = 1'b0;
    @(posedge clk);
    #1;
    cyc(GS_PLAY, 1'b0, 1'b1, 1'b0, 1'b1, z, "reset");
    rst = 1'b0;

    // Full level-1 schedule, tick every cycle.
    restart(8'd1);
    for (int n = 1; n <= 400; n++) cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, sched_exp(n), "sched");

    // Fright at phase 0 counter 10; phase counter resumes at 10 afterwards.
    restart(8'd1);
    for (int n = 1; n <= 10; n++) cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, sched_exp(n), "pre_fright");
    cyc(GS_PLAY, 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd2, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0), "pellet");
    fright_run(24, 0, 24, 3'd0, 2'd0, z, "fright");
    for (int n = 11; n <= 28; n++) cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, sched_exp(n), "post_fright");

    // Table: combo saturation, pellet restart, pellet+eat, then level 7.
    for (int i = 0; i < 10; i++) begin
      lvl = vecs[i].lvl;
      cyc(vecs[i].gs, vecs[i].rl, vecs[i].pp, vecs[i].ge, vecs[i].tk, vecs[i].e, "table");
    end
    fright_run(24, 0, 24, 3'd0, 2'd0, z, "fright_restarted");
    for (int i = 10; i < 15; i++) begin
      lvl = vecs[i].lvl;
      cyc(vecs[i].gs, vecs[i].rl, vecs[i].pp, vecs[i].ge, vecs[i].tk, vecs[i].e, "table_lvl7");
    end

    // Pause mid-fright at level 2 (fright 20 ticks).
    restart(8'd2);
    for (int n = 1; n <= 5; n++) cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, z, "l2_pre");
    cyc(GS_PLAY, 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd2, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0), "l2_pellet");
    fright_run(20, 0, 6, 3'd0, 2'd0, z, "l2_fright");
    for (int i = 0; i < 100; i++) begin
      cyc(GS_PAUSE, 1'b0, (i % 7 == 3), (i % 5 == 1), 1'b1,
          mk(2'd2, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0), "pause");
    end
    fright_run(20, 6, 14, 3'd0, 2'd0, z, "resume");
    for (int n = 6; n <= 27; n++) cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, z, "l2_phase");
    cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, mk(2'd1, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0), "l2_expiry");

    // Reload during fright, level latching.
    restart(8'd1);
    for (int n = 1; n <= 30; n++) cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, sched_exp(n), "pre_reload");
    cyc(GS_PLAY, 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd2, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0), "pellet_ph1");
    fright_run(24, 0, 3, 3'd1, 2'd0, z, "fright_ph1");
    cyc(GS_PLAY, 1'b1, 1'b0, 1'b1, 1'b1, z, "reload");
    cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, z, "after_reload");
    lvl = 8'd7;
    cyc(GS_PLAY, 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd2, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0), "level_latched");
    cyc(GS_PLAY, 1'b1, 1'b0, 1'b0, 1'b0, z, "reload_lvl7");
    cyc(GS_PLAY, 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0), "lvl7_pellet");

    // Pellet on a phase-expiry tick: expiry deferred past the fright.
    restart(8'd1);
    for (int n = 1; n <= 27; n++) cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, sched_exp(n), "pre_expiry");
    cyc(GS_PLAY, 1'b0, 1'b1, 1'b0, 1'b1, mk(2'd2, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0), "pellet_on_expiry");
    fright_run(24, 0, 24, 3'd0, 2'd0, z, "fright_expiry");
    cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, mk(2'd1, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0), "deferred_expiry");

    // Reset mid-phase 3 with fright active.
    restart(8'd1);
    for (int n = 1; n <= 140; n++) cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, sched_exp(n), "to_ph3");
    cyc(GS_PLAY, 1'b0, 1'b1, 1'b0, 1'b0, mk(2'd2, 3'd3, 1'b1, 1'b1, 1'b0, 2'd0), "pellet_ph3");
    rst = 1'b1;
    cyc(GS_PLAY, 1'b0, 1'b0, 1'b1, 1'b1, z, "mid_reset");
    rst = 1'b0;
    cyc(GS_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, z, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
